// File: rtl/dmem_access_unit.sv
// Data-memory access stage: turns LDUR/STUR into a req/ack transaction to a
// multi-cycle memory, stalling the datapath and flagging bad or timed-out accesses.
module dmem_access_unit #(
  parameter int MEM_AW  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [63:0]       Address,
  input  logic [63:0]       WriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [63:0]       ReadData,
  output logic              Stall,
  output logic              Err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t     state_r, state_s;
  logic [7:0] cnt_r;
  logic       start_s, bad_s, timeout_s, stall_s;

  // An access is rejected if it is both load and store, not doubleword aligned,
  // or reaches beyond the memory's byte-address space.
  function automatic logic is_bad(input logic rd, input logic wr, input logic [63:0] addr);
    logic hi_s;
    hi_s = (addr[63:MEM_AW] != {(64-MEM_AW){1'b0}});
    return (rd & wr) | (addr[2:0] != 3'd0) | hi_s;
  endfunction

  assign start_s   = MemRead | MemWrite;
  assign bad_s     = is_bad(MemRead, MemWrite, Address);
  assign timeout_s = (cnt_r == LIMIT);

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next-state and stall decode
  always_comb begin
    state_s = state_r;
    stall_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          stall_s = 1'b1;
          state_s = bad_s ? DONE : BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        if (mem_ack || timeout_s) state_s = DONE;
        else                      state_s = BUSY;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Stall is masked during reset so an abandoned access releases the pipeline at once.
  assign Stall = stall_s & ~Reset;

  // Memory bus, timeout counter, error flag and load result
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ReadData  <= 64'd0;
      Err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {MEM_AW{1'b0}};
      mem_wdata <= 64'd0;
      cnt_r     <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= 8'd0;
          if (start_s && !bad_s) begin
            Err       <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= Address[MEM_AW-1:0];
            mem_wdata <= WriteData;
          end else begin
            Err <= start_s;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            Err     <= 1'b0;
            if (!mem_we) ReadData <= mem_rdata;
            else         ReadData <= ReadData;
          end else if (timeout_s) begin
            mem_req <= 1'b0;
            Err     <= 1'b1;
            if (!mem_we) ReadData <= 64'd0;
            else         ReadData <= ReadData;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        DONE: begin
          Err <= 1'b0;
        end
        default: begin
          Err     <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed vector table, reset and
// spurious-ack sequences, then randomized accesses against a transaction-level model.
module tb_dmem_access_unit;
  localparam int AW = 16;
  localparam int TO = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [63:0]   Address, WriteData, ReadData, mem_wdata, mem_rdata;
  logic          MemRead, MemWrite, Stall, Err, mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;
  logic [63:0] model_rd;

  dmem_access_unit #(.MEM_AW(AW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Address(Address), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData), .Stall(Stall),
    .Err(Err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          ack_at;   // BUSY cycle carrying the ack; 0 = never
    logic [63:0] rdata;
    int          exp_stall;
    int          exp_req;
    logic        exp_err;
    logic [63:0] exp_rd;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Whole-transaction expectation: derived from the access rules, not cycle by cycle.
  task automatic ref_model(input logic rd, input logic wr, input logic [63:0] addr,
                           input int ack_at, input logic [63:0] rdata,
                           output int s, output int r, output logic e, output logic [63:0] q);
    bit bad;
    bad = (rd && wr) || (addr % 64'd8 != 64'd0) || (addr >= (64'd1 << AW));
    if (bad) begin
      s = 1; r = 0; e = 1'b1;
    end else if (ack_at >= 1 && ack_at <= TO) begin
      s = 1 + ack_at; r = ack_at; e = 1'b0;
      if (rd) model_rd = rdata;
    end else begin
      s = 1 + TO; r = TO; e = 1'b1;
      if (rd) model_rd = 64'd0;
    end
    q = model_rd;
  endtask

  task automatic do_access(input string tag, input vec_t v);
    int  stall_n = 0;
    int  req_n   = 0;
    int  bus_bad = 0;
    bit  done    = 0;
    MemRead   = v.rd;
    MemWrite  = v.wr;
    Address   = v.addr;
    WriteData = v.wdata;
    mem_rdata = v.rdata;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (Stall) begin
        stall_n++;
        if (mem_req) begin
          req_n++;
          if (mem_addr !== v.addr[AW-1:0] || mem_we !== v.wr || mem_wdata !== v.wdata)
            bus_bad++;
          mem_ack = (req_n == v.ack_at);
        end
        step();
        mem_ack = 1'b0;
      end else begin
        done = 1;
        chk({tag, " err"}, 64'(Err), 64'(v.exp_err));
        chk({tag, " readdata"}, ReadData, v.exp_rd);
        chk({tag, " req_in_done"}, 64'(mem_req), 64'd0);
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL %s done_timeout: got stall held expected release", tag);
    end
    chk({tag, " stall_cycles"}, 64'(stall_n), 64'(v.exp_stall));
    chk({tag, " req_cycles"}, 64'(req_n), 64'(v.exp_req));
    chk({tag, " bus_stable"}, 64'(bus_bad), 64'd0);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    step();
    #1;
    chk({tag, " err_cleared"}, 64'(Err), 64'd0);
    chk({tag, " idle_stall"}, 64'(Stall), 64'd0);
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 64'h10,    64'hDEAD_BEEF_0000_0001, 2, 64'h0,    3, 2, 1'b0, 64'h0};
    tbl[1]  = '{1'b1, 1'b0, 64'h10,    64'h0,                   1, 64'h1234, 2, 1, 1'b0, 64'h1234};
    tbl[2]  = '{1'b1, 1'b0, 64'h13,    64'h0,                   1, 64'h9999, 1, 0, 1'b1, 64'h1234};
    tbl[3]  = '{1'b1, 1'b0, 64'h10000, 64'h0,                   1, 64'h9999, 1, 0, 1'b1, 64'h1234};
    tbl[4]  = '{1'b1, 1'b1, 64'h10,    64'h0,                   1, 64'h9999, 1, 0, 1'b1, 64'h1234};
    tbl[5]  = '{1'b1, 1'b0, 64'h18,    64'h0,                   0, 64'h7777, 5, 4, 1'b1, 64'h0};
    tbl[6]  = '{1'b1, 1'b0, 64'h20,    64'h0,                   4, 64'hCAFE, 5, 4, 1'b0, 64'hCAFE};
    tbl[7]  = '{1'b0, 1'b1, 64'h28,    64'h1111_2222,           3, 64'h0,    4, 3, 1'b0, 64'hCAFE};
    tbl[8]  = '{1'b0, 1'b1, 64'h30,    64'h3333,                0, 64'h0,    5, 4, 1'b1, 64'hCAFE};
    tbl[9]  = '{1'b1, 1'b0, 64'hFFF8,  64'h0,                   1, 64'h5555, 2, 1, 1'b0, 64'h5555};
    tbl[10] = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h0,     1, 64'h1,    1, 0, 1'b1, 64'h5555};
    tbl[11] = '{1'b0, 1'b1, 64'h4,     64'hAB,                  1, 64'h0,    1, 0, 1'b1, 64'h5555};

    Reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = 64'd0;
    WriteData = 64'd0; mem_rdata = 64'd0; mem_ack = 1'b0;
    #2;
    chk("reset readdata", ReadData, 64'd0);
    chk("reset err", 64'(Err), 64'd0);
    chk("reset mem_req", 64'(mem_req), 64'd0);
    chk("reset mem_we", 64'(mem_we), 64'd0);
    chk("reset mem_addr", 64'(mem_addr), 64'd0);
    chk("reset mem_wdata", mem_wdata, 64'd0);
    chk("reset stall", 64'(Stall), 64'd0);
    step(); step();
    Reset = 1'b0;
    step();

    for (int i = 0; i < 12; i++) do_access($sformatf("vec%0d", i), tbl[i]);
    model_rd = 64'h5555;

    // Non-memory instructions: no stall, no request.
    for (int i = 0; i < 4; i++) begin
      Address = {$urandom, $urandom};
      #1;
      chk("nonmem stall", 64'(Stall), 64'd0);
      step();
      chk("nonmem req", 64'(mem_req), 64'd0);
    end

    // Spurious ack while idle.
    mem_ack = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    mem_ack = 1'b0;
    #1;
    chk("spurious readdata", ReadData, model_rd);
    chk("spurious req", 64'(mem_req), 64'd0);
    chk("spurious err", 64'(Err), 64'd0);

    // Reset in the middle of a load.
    MemRead = 1'b1; Address = 64'h40;
    step(); step();
    chk("midreset req_before", 64'(mem_req), 64'd1);
    Reset = 1'b1;
    #1;
    chk("midreset req", 64'(mem_req), 64'd0);
    chk("midreset stall", 64'(Stall), 64'd0);
    chk("midreset readdata", ReadData, 64'd0);
    MemRead = 1'b0;
    step();
    Reset = 1'b0;
    model_rd = 64'd0;
    step();
    chk("postreset stall", 64'(Stall), 64'd0);
    do_access("postreset", '{1'b1, 1'b0, 64'h40, 64'h0, 2, 64'h0F0F, 3, 2, 1'b0, 64'h0F0F});
    model_rd = 64'h0F0F;

    // Randomized accesses checked against the transaction model.
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      int   op, kind;
      op   = int'($urandom_range(0, 5));
      kind = int'($urandom_range(0, 9));
      v.rd = (op <= 2) || (op == 5);
      v.wr = (op >= 3);
      if (kind == 0)      v.addr = {48'd0, 16'($urandom)} | 64'd1;
      else if (kind == 1) v.addr = 64'd1 << $urandom_range(AW, 63);
      else                v.addr = {48'd0, 13'($urandom), 3'b000};
      v.wdata  = {$urandom, $urandom};
      v.rdata  = {$urandom, $urandom};
      v.ack_at = int'($urandom_range(0, TO + 1));
      ref_model(v.rd, v.wr, v.addr, v.ack_at, v.rdata, v.exp_stall, v.exp_req, v.exp_err, v.exp_rd);
      do_access($sformatf("rnd%0d", i), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
